// File: rtl/proc_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : proc_control_unit_if
// Description : Instruction/flag inputs and strobe outputs of the control FSM.
// Revision    : 1.0
// ============================================================================
interface proc_control_unit_if;
    logic        run;
    logic [15:0] ir;
    logic        g_nz;
    logic [0:9]  mux_sel;
    logic [6:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic        addsub;
    logic        ir_in;
    logic        addr_in;
    logic        pc_inc;
    logic        dout_in;
    logic        w_d;
    logic        done;

    modport master (
        output run, ir, g_nz,
        input  mux_sel, r_in, a_in, g_in, addsub, ir_in, addr_in,
               pc_inc, dout_in, w_d, done
    );

    modport slave (
        input  run, ir, g_nz,
        output mux_sel, r_in, a_in, g_in, addsub, ir_in, addr_in,
               pc_inc, dout_in, w_d, done
    );
endinterface
`default_nettype wire

// File: rtl/proc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : proc_control_unit
// Description : Multi-cycle fetch/decode/execute control FSM of the 16-bit
//               teaching processor; outputs decode from state, ir and g_nz.
// Revision    : 1.0
// ============================================================================
module proc_control_unit (
    input  wire logic           clock,
    input  wire logic           resetn,
    proc_control_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_EX1    = 3'd4,
        S_EX2    = 3'd5,
        S_EX3    = 3'd6
    } state_t;

    localparam logic [2:0] c_op_mv   = 3'b000;
    localparam logic [2:0] c_op_mvi  = 3'b001;
    localparam logic [2:0] c_op_add  = 3'b010;
    localparam logic [2:0] c_op_sub  = 3'b011;
    localparam logic [2:0] c_op_ld   = 3'b100;
    localparam logic [2:0] c_op_st   = 3'b101;
    localparam logic [2:0] c_op_mvnz = 3'b110;

    localparam logic [0:9] c_sel_din = 10'b1000000000;
    localparam logic [0:9] c_sel_r0  = 10'b0100000000;
    localparam logic [0:9] c_sel_pc  = 10'b0000000010;
    localparam logic [0:9] c_sel_g   = 10'b0000000001;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  w_op;
    logic [2:0]  w_rx;
    logic [2:0]  w_ry;
    logic        w_uses_y;
    logic        w_reserved;
    logic [0:9]  w_sel_x;
    logic [0:9]  w_sel_y;
    logic [6:0]  w_load_x;
    logic        w_unused_ir;

    logic [0:9]  w_mux_sel;
    logic [6:0]  w_r_in;
    logic        w_a_in;
    logic        w_g_in;
    logic        w_addsub;
    logic        w_ir_in;
    logic        w_addr_in;
    logic        w_pc_inc;
    logic        w_dout_in;
    logic        w_w_d;
    logic        w_done;

    assign w_op        = bus.ir[15:13];
    assign w_rx        = bus.ir[12:10];
    assign w_ry        = bus.ir[9:7];
    assign w_unused_ir = ^bus.ir[6:0];

    // Register index 7 does not exist; any opcode naming it retires as a no-op.
    assign w_uses_y   = (w_op != c_op_mvi) && (w_op != 3'b111);
    assign w_reserved = (w_op == 3'b111) || (w_rx == 3'd7) ||
                        (w_uses_y && (w_ry == 3'd7));

    assign w_sel_x  = c_sel_r0 >> w_rx;
    assign w_sel_y  = c_sel_r0 >> w_ry;
    assign w_load_x = 7'b0000001 << w_rx;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mux_sel    = '0;
        w_r_in       = '0;
        w_a_in       = 1'b0;
        w_g_in       = 1'b0;
        w_addsub     = 1'b0;
        w_ir_in      = 1'b0;
        w_addr_in    = 1'b0;
        w_pc_inc     = 1'b0;
        w_dout_in    = 1'b0;
        w_w_d        = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_mux_sel    = c_sel_pc;
                w_addr_in    = 1'b1;
                w_pc_inc     = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_state_next = S_DECODE;
            end
            S_DECODE: begin
                w_ir_in      = 1'b1;
                w_state_next = S_EX1;
            end
            S_EX1: begin
                w_state_next = S_EX2;
                if (w_reserved) begin
                    w_done = 1'b1;
                end else begin
                    case (w_op)
                        c_op_mv: begin
                            w_mux_sel = w_sel_y;
                            w_r_in    = w_load_x;
                            w_done    = 1'b1;
                        end
                        c_op_mvi: begin
                            w_mux_sel = c_sel_pc;
                            w_addr_in = 1'b1;
                            w_pc_inc  = 1'b1;
                        end
                        c_op_add, c_op_sub: begin
                            w_mux_sel = w_sel_x;
                            w_a_in    = 1'b1;
                        end
                        c_op_ld, c_op_st: begin
                            w_mux_sel = w_sel_y;
                            w_addr_in = 1'b1;
                        end
                        c_op_mvnz: begin
                            w_done = 1'b1;
                            if (bus.g_nz) begin
                                w_mux_sel = w_sel_y;
                                w_r_in    = w_load_x;
                            end
                        end
                        default: w_done = 1'b1;
                    endcase
                end
            end
            S_EX2: begin
                w_state_next = S_EX3;
                case (w_op)
                    c_op_add, c_op_sub: begin
                        w_mux_sel = w_sel_y;
                        w_g_in    = 1'b1;
                        w_addsub  = (w_op == c_op_sub);
                    end
                    c_op_st: begin
                        w_mux_sel = w_sel_x;
                        w_dout_in = 1'b1;
                        w_w_d     = 1'b1;
                        w_done    = 1'b1;
                    end
                    c_op_mvi, c_op_ld: ;
                    default: w_state_next = S_IDLE;
                endcase
            end
            S_EX3: begin
                w_state_next = S_IDLE;
                case (w_op)
                    c_op_mvi, c_op_ld: begin
                        w_mux_sel = c_sel_din;
                        w_r_in    = w_load_x;
                        w_done    = 1'b1;
                    end
                    c_op_add, c_op_sub: begin
                        w_mux_sel = c_sel_g;
                        w_r_in    = w_load_x;
                        w_done    = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: w_state_next = S_IDLE;
        endcase

        // Every instruction's final step hands straight to the next fetch.
        if (w_done) w_state_next = bus.run ? S_FETCH : S_IDLE;
    end

    assign bus.mux_sel = w_mux_sel;
    assign bus.r_in    = w_r_in;
    assign bus.a_in    = w_a_in;
    assign bus.g_in    = w_g_in;
    assign bus.addsub  = w_addsub;
    assign bus.ir_in   = w_ir_in;
    assign bus.addr_in = w_addr_in;
    assign bus.pc_inc  = w_pc_inc;
    assign bus.dout_in = w_dout_in;
    assign bus.w_d     = w_w_d;
    assign bus.done    = w_done;

endmodule
`default_nettype wire

// File: tb/tb_proc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_control_unit
// Description : Directed-vector bench for the processor control FSM.
// Revision    : 1.0
// ============================================================================
module tb_proc_control_unit;

    localparam logic [0:9] c_m_none = 10'b0000000000;
    localparam logic [0:9] c_m_din  = 10'b1000000000;
    localparam logic [0:9] c_m_r0   = 10'b0100000000;
    localparam logic [0:9] c_m_r1   = 10'b0010000000;
    localparam logic [0:9] c_m_r3   = 10'b0000100000;
    localparam logic [0:9] c_m_r4   = 10'b0000010000;
    localparam logic [0:9] c_m_r5   = 10'b0000001000;
    localparam logic [0:9] c_m_pc   = 10'b0000000010;
    localparam logic [0:9] c_m_g    = 10'b0000000001;

    // Flag order: a_in g_in addsub ir_in addr_in pc_inc dout_in w_d done
    localparam logic [8:0] c_f_none = 9'b000000000;
    localparam logic [8:0] c_f_ain  = 9'b100000000;
    localparam logic [8:0] c_f_gin  = 9'b010000000;
    localparam logic [8:0] c_f_sub  = 9'b001000000;
    localparam logic [8:0] c_f_irin = 9'b000100000;
    localparam logic [8:0] c_f_addr = 9'b000010000;
    localparam logic [8:0] c_f_pcin = 9'b000001000;
    localparam logic [8:0] c_f_dout = 9'b000000100;
    localparam logic [8:0] c_f_wd   = 9'b000000010;
    localparam logic [8:0] c_f_done = 9'b000000001;

    logic clk;
    logic resetn;
    int   r_vectors;
    int   r_miscompares;

    proc_control_unit_if bus ();

    proc_control_unit dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        r_vectors++;
        if (obs !== exp) begin
            r_miscompares++;
            $display("FAIL %s: got mux=%b r_in=%b flags=%b, want mux=%b r_in=%b flags=%b",
                     tag, obs[25:16], obs[15:9], obs[8:0], exp[25:16], exp[15:9], exp[8:0]);
        end
    endtask

    task automatic expect_out(input string tag, input logic [0:9] m,
                              input logic [6:0] r, input logic [8:0] f);
        logic [25:0] obs;
        obs = {bus.mux_sel, bus.r_in, bus.a_in, bus.g_in, bus.addsub, bus.ir_in,
               bus.addr_in, bus.pc_inc, bus.dout_in, bus.w_d, bus.done};
        chk(tag, obs, {m, r, f});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks FETCH, WAIT, DECODE; the instruction appears on ir once DECODE has loaded it.
    task automatic fetch_seq(input string tag, input logic [15:0] instr, input logic run_in_decode);
        tick(); expect_out({tag, "_fetch"},  c_m_pc,   7'b0, c_f_addr | c_f_pcin);
        tick(); expect_out({tag, "_wait"},   c_m_none, 7'b0, c_f_none);
        tick(); expect_out({tag, "_decode"}, c_m_none, 7'b0, c_f_irin);
        bus.ir  = instr;
        bus.run = run_in_decode;
    endtask

    initial begin
        r_vectors     = 0;
        r_miscompares = 0;
        resetn   = 1'b0;
        bus.run  = 1'b1;
        bus.ir   = 16'h0000;
        bus.g_nz = 1'b0;

        tick(); tick();
        expect_out("reset_hold", c_m_none, 7'b0, c_f_none);
        resetn = 1'b1;

        fetch_seq("mv", 16'h0A80, 1'b1);
        tick(); expect_out("mv_ex1", c_m_r5, 7'b0000100, c_f_done);

        fetch_seq("add", 16'h4580, 1'b1);
        tick(); expect_out("add_ex1", c_m_r1, 7'b0, c_f_ain);
        tick(); expect_out("add_ex2", c_m_r3, 7'b0, c_f_gin);
        tick(); expect_out("add_ex3", c_m_g,  7'b0000010, c_f_done);

        fetch_seq("sub", 16'h6580, 1'b1);
        tick(); expect_out("sub_ex1", c_m_r1, 7'b0, c_f_ain);
        tick(); expect_out("sub_ex2", c_m_r3, 7'b0, c_f_gin | c_f_sub);
        tick(); expect_out("sub_ex3", c_m_g,  7'b0000010, c_f_done);

        fetch_seq("mvi", 16'h2000, 1'b1);
        tick(); expect_out("mvi_ex1", c_m_pc,   7'b0, c_f_addr | c_f_pcin);
        tick(); expect_out("mvi_ex2", c_m_none, 7'b0, c_f_none);
        tick(); expect_out("mvi_ex3", c_m_din,  7'b0000001, c_f_done);

        fetch_seq("st", 16'hA200, 1'b1);
        tick(); expect_out("st_ex1", c_m_r4, 7'b0, c_f_addr);
        tick(); expect_out("st_ex2", c_m_r0, 7'b0, c_f_dout | c_f_wd | c_f_done);

        bus.g_nz = 1'b1;
        fetch_seq("mvnz1", 16'hD880, 1'b1);
        tick(); expect_out("mvnz_gnz1", c_m_r1, 7'b1000000, c_f_done);

        bus.g_nz = 1'b0;
        fetch_seq("mvnz0", 16'hD880, 1'b1);
        tick(); expect_out("mvnz_gnz0", c_m_none, 7'b0, c_f_done);

        fetch_seq("rsv_op", 16'hE000, 1'b1);
        tick(); expect_out("rsv_op_ex1", c_m_none, 7'b0, c_f_done);

        fetch_seq("rsv_rx7", 16'h1C80, 1'b1);
        tick(); expect_out("rsv_rx7_ex1", c_m_none, 7'b0, c_f_done);

        fetch_seq("ld", 16'h8080, 1'b0);
        tick(); expect_out("ld_ex1", c_m_r1,   7'b0, c_f_addr);
        tick(); expect_out("ld_ex2", c_m_none, 7'b0, c_f_none);
        tick(); expect_out("ld_ex3", c_m_din,  7'b0000001, c_f_done);
        tick(); expect_out("idle_after_ld", c_m_none, 7'b0, c_f_none);
        tick(); expect_out("idle_stays",    c_m_none, 7'b0, c_f_none);

        // Asynchronous reset in the middle of an add.
        bus.run = 1'b1;
        fetch_seq("add_rst", 16'h4580, 1'b1);
        tick(); expect_out("add_rst_ex1", c_m_r1, 7'b0, c_f_ain);
        #2 resetn = 1'b0;
        #1 expect_out("async_reset", c_m_none, 7'b0, c_f_none);
        tick(); expect_out("reset_held", c_m_none, 7'b0, c_f_none);
        resetn = 1'b1;
        tick(); expect_out("refetch", c_m_pc, 7'b0, c_f_addr | c_f_pcin);

        $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
